spi_pixel_sequencer: RTL and testbench
======================================

Name: spi_pixel_sequencer

Overview:
- System-clock-domain controller for the SPI pixel port.
- Synchronises the SPI core's chip-select and word-done flags into clk_i.
- Captures each received pixel word and hands it to the grayscale/Sobel datapath over a valid/ready handshake.
- Queues processed results in a small FIFO and presents the next one on the SPI core's transmit word, so results stream back on the following transfers.

Parameters:
- MAX_PIXEL_BITS, 24, width of one SPI word and pixel; must match the SPI core.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input flag; minimum 2.
- FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.

Ports:
- clk_i  in  1  system clock.
- nreset_i  in  1  asynchronous active-low reset.
- spi_cs_i  in  1  raw chip-select pin, active low, asynchronous to clk_i.
- spi_done_i  in  1  SPI core word-done flag, asynchronous to clk_i.
- spi_rx_data_i  in  MAX_PIXEL_BITS  SPI core received word; stable while done is high.
- spi_tx_data_o  out  MAX_PIXEL_BITS  word the SPI core loads at each word start.
- px_valid_o  out  1  captured pixel available.
- px_data_o  out  MAX_PIXEL_BITS  captured pixel.
- px_ready_i  in  1  datapath accepts the pixel.
- res_valid_i  in  1  datapath result available.
- res_data_i  in  MAX_PIXEL_BITS  datapath result.
- res_ready_o  out  1  result FIFO not full.
- frame_start_o  out  1  one-cycle pulse when a transaction begins.
- busy_o  out  1  FSM not in IDLE.
- overrun_o  out  1  sticky: a received pixel was dropped.
- underrun_o  out  1  sticky: a word was sent with no result queued.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; synchroniser flops 0 for done and 1 for cs. Synchronised cs is therefore inactive and no frame_start fires as reset releases.
- Synchronisation: cs_n_s and done_s are SYNC_STAGES flops deep. Edges are detected against one additional registered copy. spi_rx_data_i is sampled only in CAPTURE; it is already stable there because done rose before the synchroniser delay expired.
- FSM:
  - IDLE: on a cs_n_s falling edge, pulse frame_start_o, flush the FIFO, load spi_tx_data_o with 0, go to ACTIVE.
  - ACTIVE: on a done_s rising edge go to CAPTURE. On a cs_n_s rising edge go to IDLE.
  - CAPTURE (one cycle):
    - If px_valid_o is 0: load px_data_o from spi_rx_data_i and set px_valid_o.
    - Else: drop the word and set overrun_o.
    - Then load the next transmit word (below) and return to ACTIVE. If cs_n_s rose during this cycle, go to IDLE instead; the capture still completes.
- Transmit load:
  - FIFO not empty: pop the head into spi_tx_data_o.
  - FIFO empty: spi_tx_data_o becomes 0 and underrun_o is set.
  - spi_tx_data_o is otherwise held.
- Pixel handshake: px_valid_o clears on the cycle after px_valid_o && px_ready_i. px_data_o is held while valid. A CS deassert does not cancel a pending pixel.
- Result FIFO:
  - Push when res_valid_i && res_ready_o.
  - res_ready_o = !full.
  - A simultaneous push and pop is allowed when full; occupancy is unchanged and the pushed word is not lost.
  - Pop while empty never decrements.
  - Pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty.
- Sticky flags clear only on reset or at the next frame_start_o.
- Latency: a word is on px_data_o (px_valid_o high) SYNC_STAGES+2 clk_i cycles after spi_done_i rises.
- busy_o = (state != IDLE).

Test Plan:
- Reset with inputs idle -> all outputs 0, no frame_start_o pulse after reset release.
- Drop spi_cs_i, raise spi_done_i with spi_rx_data_i=24'hA1B2C3, px_ready_i=1 -> frame_start_o pulses once; px_data_o=24'hA1B2C3 with px_valid_o high exactly SYNC_STAGES+2 cycles after done; valid clears the next cycle.
- Push results 24'h000011 and 24'h000022, then two done edges -> spi_tx_data_o=24'h000011 after the first capture, 24'h000022 after the second; underrun_o stays 0. A third done edge -> spi_tx_data_o=0, underrun_o=1.
- Hold px_ready_i=0 across two done edges carrying 24'h111111 then 24'h222222 -> px_data_o stays 24'h111111, overrun_o=1.
- Push 4 results with no pops -> res_ready_o=0. Push and pop on the same cycle while full -> stays full; the pushed word comes out fourth.
- Raise spi_cs_i during CAPTURE, then drop it again -> the capture completes and the FSM goes to IDLE; the new frame flushes the FIFO and clears the sticky flags.

Source files
------------

// File: rtl/spi_pixel_sequencer.sv
// System-clock-side sequencer for the SPI pixel port: synchronises the SPI core flags,
// hands received pixels to the datapath and streams queued results back as transmit words.
module spi_pixel_sequencer #(
  parameter int MAX_PIXEL_BITS = 24,
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      spi_cs_i,
  input  logic                      spi_done_i,
  input  logic [MAX_PIXEL_BITS-1:0] spi_rx_data_i,
  output logic [MAX_PIXEL_BITS-1:0] spi_tx_data_o,
  output logic                      px_valid_o,
  output logic [MAX_PIXEL_BITS-1:0] px_data_o,
  input  logic                      px_ready_i,
  input  logic                      res_valid_i,
  input  logic [MAX_PIXEL_BITS-1:0] res_data_i,
  output logic                      res_ready_o,
  output logic                      frame_start_o,
  output logic                      busy_o,
  output logic                      overrun_o,
  output logic                      underrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, CAPTURE} state_e;

  // Handshakes: a pixel transfers on a clock edge where px_valid_o && px_ready_i,
  // a result transfers where res_valid_i && res_ready_o; valid never drops without a transfer.
  state_e                    state_q, state_d;
  logic [SYNC_STAGES-1:0]    cs_sync_q, done_sync_q;
  logic                      cs_prev_q, done_prev_q;
  logic [MAX_PIXEL_BITS-1:0] fifo_q [FIFO_DEPTH];
  logic [AW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_PIXEL_BITS-1:0] tx_q, tx_d, px_data_q, px_data_d;
  logic                      px_valid_q, px_valid_d;
  logic                      frame_start_q, frame_start_d;
  logic                      overrun_q, overrun_d, underrun_q, underrun_d;
  logic                      res_ready_q, res_ready_d;

  logic cs_n_s, done_s, cs_fall, cs_rise, done_rise;
  logic fifo_empty, fifo_full, push, full_nxt, empty_nxt;

  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign done_s    = done_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_n_s;
  assign cs_rise   = ~cs_prev_q & cs_n_s;
  assign done_rise = done_s & ~done_prev_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = res_valid_i && res_ready_q;

  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    px_valid_d    = px_valid_q;
    px_data_d     = px_data_q;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    underrun_d    = underrun_q;
    wr_ptr_d      = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (px_valid_q && px_ready_i) px_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          tx_d          = '0;
          overrun_d     = 1'b0;
          underrun_d    = 1'b0;
          // Flush by catching up with the writer, so a push on this same edge survives.
          rd_ptr_d      = wr_ptr_q;
        end
      end
      ACTIVE: begin
        if (done_rise)    state_d = CAPTURE;
        else if (cs_rise) state_d = IDLE;
      end
      CAPTURE: begin
        if (!px_valid_q) begin
          px_data_d  = spi_rx_data_i;
          px_valid_d = 1'b1;
        end else begin
          overrun_d  = 1'b1;
        end
        if (!fifo_empty) begin
          tx_d     = fifo_q[rd_ptr_q[AW-1:0]];
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
          tx_d       = '0;
          underrun_d = 1'b1;
        end
        // Level test also catches a CS release that coincided with the done edge.
        state_d = cs_n_s ? IDLE : ACTIVE;
      end
      default: state_d = IDLE;
    endcase
    full_nxt    = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_nxt   = (wr_ptr_d == rd_ptr_d);
    // A full FIFO still accepts a word in the cycle it is guaranteed to pop.
    res_ready_d = !full_nxt || ((state_d == CAPTURE) && !empty_nxt);
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q       <= IDLE;
      cs_sync_q     <= '1;
      done_sync_q   <= '0;
      cs_prev_q     <= 1'b1;
      done_prev_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tx_q          <= '0;
      px_valid_q    <= 1'b0;
      px_data_q     <= '0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
      res_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      done_sync_q   <= {done_sync_q[SYNC_STAGES-2:0], spi_done_i};
      cs_prev_q     <= cs_n_s;
      done_prev_q   <= done_s;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tx_q          <= tx_d;
      px_valid_q    <= px_valid_d;
      px_data_q     <= px_data_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      underrun_q    <= underrun_d;
      res_ready_q   <= res_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= res_data_i;
  end

  assign spi_tx_data_o = tx_q;
  assign px_valid_o    = px_valid_q;
  assign px_data_o     = px_data_q;
  assign res_ready_o   = res_ready_q;
  assign frame_start_o = frame_start_q;
  assign busy_o        = (state_q != IDLE);
  assign overrun_o     = overrun_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_spi_pixel_sequencer.sv
// Self-checking bench for spi_pixel_sequencer: directed scenarios plus a randomized frame,
// checked against a queue-based model of pixel capture, result FIFO and sticky flags.
module tb_spi_pixel_sequencer;

  localparam int W     = 24;
  localparam int SYNC  = 2;
  localparam int DEPTH = 4;

  logic         clk_i = 1'b0, nreset_i = 1'b0;
  logic         spi_cs_i = 1'b1, spi_done_i = 1'b0;
  logic [W-1:0] spi_rx_data_i = '0, res_data_i = '0;
  logic         px_ready_i = 1'b1, res_valid_i = 1'b0;
  logic [W-1:0] spi_tx_data_o, px_data_o;
  logic         px_valid_o, res_ready_o, frame_start_o, busy_o, overrun_o, underrun_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_px = '0;
  logic         m_px_valid = 1'b0, m_ov = 1'b0, m_ur = 1'b0;

  always #5 clk_i = ~clk_i;

  spi_pixel_sequencer #(.MAX_PIXEL_BITS(W), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .spi_cs_i(spi_cs_i), .spi_done_i(spi_done_i),
    .spi_rx_data_i(spi_rx_data_i), .spi_tx_data_o(spi_tx_data_o),
    .px_valid_o(px_valid_o), .px_data_o(px_data_o), .px_ready_i(px_ready_i),
    .res_valid_i(res_valid_i), .res_data_i(res_data_i), .res_ready_o(res_ready_o),
    .frame_start_o(frame_start_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .underrun_o(underrun_o)
  );

  // Result handshakes observed at the edge enter the model queue.
  always @(posedge clk_i)
    if (nreset_i && res_valid_i && res_ready_o) exp_q.push_back(res_data_i);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame();
    int pulses;
    pulses = 0;
    spi_cs_i = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      if (frame_start_o) pulses++;
    end
    exp_q.delete();
    m_ov = 1'b0;
    m_ur = 1'b0;
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL frame_pulses: got %0d want 1", pulses); end
    n_cmp++; if (spi_tx_data_o !== '0) begin n_err++; $display("FAIL frame_tx: got %h want 0", spi_tx_data_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL frame_busy: got %b want 1", busy_o); end
    n_cmp++; if ({overrun_o, underrun_o} !== 2'b00) begin n_err++; $display("FAIL frame_sticky: got ov=%b ur=%b want 0 0", overrun_o, underrun_o); end
    n_cmp++; if (res_ready_o !== 1'b1) begin n_err++; $display("FAIL frame_ready: got %b want 1", res_ready_o); end
  endtask

  task automatic end_frame();
    spi_cs_i = 1'b1;
    repeat (SYNC + 3) @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL end_busy: got %b want 0", busy_o); end
  endtask

  task automatic push_result(input logic [W-1:0] d);
    logic exp_rdy;
    exp_rdy = (exp_q.size() < DEPTH);
    n_cmp++; if (res_ready_o !== exp_rdy) begin n_err++; $display("FAIL push_ready: got %b want %b", res_ready_o, exp_rdy); end
    res_data_i  = d;
    res_valid_i = 1'b1;
    @(negedge clk_i);
    res_valid_i = 1'b0;
  endtask

  task automatic do_word(input logic [W-1:0] d);
    logic [W-1:0] exp_tx;
    logic         was_valid;
    was_valid = m_px_valid;
    if (!m_px_valid) begin m_px = d; m_px_valid = 1'b1; end
    else m_ov = 1'b1;
    if (exp_q.size() > 0) exp_tx = exp_q.pop_front();
    else begin exp_tx = '0; m_ur = 1'b1; end
    spi_rx_data_i = d;
    spi_done_i    = 1'b1;
    repeat (SYNC + 1) @(negedge clk_i);
    if (!was_valid) begin
      n_cmp++; if (px_valid_o !== 1'b0) begin n_err++; $display("FAIL px_early: got valid=%b want 0", px_valid_o); end
    end
    @(negedge clk_i);
    n_cmp++; if (px_valid_o !== 1'b1) begin n_err++; $display("FAIL px_valid: got %b want 1", px_valid_o); end
    n_cmp++; if (px_data_o !== m_px) begin n_err++; $display("FAIL px_data: got %h want %h", px_data_o, m_px); end
    n_cmp++; if (spi_tx_data_o !== exp_tx) begin n_err++; $display("FAIL tx_data: got %h want %h", spi_tx_data_o, exp_tx); end
    n_cmp++; if (overrun_o !== m_ov) begin n_err++; $display("FAIL overrun: got %b want %b", overrun_o, m_ov); end
    n_cmp++; if (underrun_o !== m_ur) begin n_err++; $display("FAIL underrun: got %b want %b", underrun_o, m_ur); end
    if (px_ready_i) begin
      @(negedge clk_i);
      n_cmp++; if (px_valid_o !== 1'b0) begin n_err++; $display("FAIL px_clear: got %b want 0", px_valid_o); end
      m_px_valid = 1'b0;
    end
    spi_done_i = 1'b0;
    repeat (SYNC + 2) @(negedge clk_i);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int pulses;
    repeat (3) @(negedge clk_i);
    n_cmp++; if ({spi_tx_data_o, px_data_o} !== '0) begin n_err++; $display("FAIL reset_data: got tx=%h px=%h want 0 0", spi_tx_data_o, px_data_o); end
    n_cmp++; if ({px_valid_o, res_ready_o, frame_start_o, busy_o, overrun_o, underrun_o} !== 6'b0)
      begin n_err++; $display("FAIL reset_flags: got %b want 000000", {px_valid_o, res_ready_o, frame_start_o, busy_o, overrun_o, underrun_o}); end
    nreset_i = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (frame_start_o) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL reset_no_frame: got %0d pulses want 0", pulses); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (res_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", res_ready_o); end
  endtask

  task automatic test_first_pixel();
    start_frame();
    do_word(24'hA1B2C3);
    end_frame();
  endtask

  task automatic test_tx_stream();
    start_frame();
    push_result(24'h000011);
    push_result(24'h000022);
    do_word(24'h123456);
    do_word(24'h654321);
    do_word(24'h0F0F0F);
    end_frame();
  endtask

  task automatic test_overrun();
    start_frame();
    px_ready_i = 1'b0;
    do_word(24'h111111);
    do_word(24'h222222);
    px_ready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (px_valid_o !== 1'b0) begin n_err++; $display("FAIL overrun_release: got %b want 0", px_valid_o); end
    m_px_valid = 1'b0;
    end_frame();
  endtask

  task automatic test_full_swap();
    start_frame();
    for (int i = 0; i < DEPTH; i++) push_result(W'(32'hC0 + i));
    n_cmp++; if (res_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", res_ready_o); end
    res_data_i  = 24'hBEEF55;
    res_valid_i = 1'b1;
    do_word(24'hAAAA01);
    res_valid_i = 1'b0;
    n_cmp++; if (res_ready_o !== 1'b0) begin n_err++; $display("FAIL swap_still_full: got %b want 0", res_ready_o); end
    n_cmp++; if (exp_q.size() !== DEPTH) begin n_err++; $display("FAIL swap_accepted: got %0d queued want %0d", exp_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) do_word(W'($urandom));
    end_frame();
  endtask

  task automatic test_cs_during_capture();
    logic [W-1:0] exp_tx;
    start_frame();
    push_result(24'h00AA00);
    push_result(24'h00BB00);
    exp_tx = exp_q.pop_front();
    m_px = 24'h5A5A5A;
    spi_rx_data_i = m_px;
    spi_done_i = 1'b1;
    @(negedge clk_i);
    spi_cs_i = 1'b1;
    repeat (SYNC + 1) @(negedge clk_i);
    n_cmp++; if (px_valid_o !== 1'b1 || px_data_o !== m_px) begin n_err++; $display("FAIL cs_capture_px: got v=%b d=%h want 1 %h", px_valid_o, px_data_o, m_px); end
    n_cmp++; if (spi_tx_data_o !== exp_tx) begin n_err++; $display("FAIL cs_capture_tx: got %h want %h", spi_tx_data_o, exp_tx); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL cs_capture_idle: got busy=%b want 0", busy_o); end
    spi_done_i = 1'b0;
    repeat (SYNC + 2) @(negedge clk_i);
    m_px_valid = 1'b0;
    start_frame();
    do_word(24'h777777);
    end_frame();
  endtask

  task automatic test_random();
    int n;
    start_frame();
    for (int w = 0; w < 10; w++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++)
        if (exp_q.size() < DEPTH) push_result(W'($urandom));
      do_word(W'($urandom));
    end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_tx_stream();
    test_overrun();
    test_full_swap();
    test_cs_during_capture();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
